// File: rtl/fifo_chain_pkg.sv
// Shared constants and helpers for the fifo_chain cascade.
package fifo_chain_pkg;

  // Legal values of the FALLTHROUGH parameter
  localparam string FT_TRUE  = "TRUE";
  localparam string FT_FALSE = "FALSE";

  // Width of a counter that must hold 0..capacity inclusive
  function automatic int level_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

endpackage

// File: rtl/fifo_chain_stage.sv
// One D-entry circular buffer stage with ASIZE+1-bit wrap pointers.
// Latency: a pushed word is visible at head after the push edge.
// Backpressure: none internal; the parent only pushes when !full and pops when !empty.
module fifo_chain_stage #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_dat,
  input  logic             pop,
  output logic [DSIZE-1:0] head,
  output logic [ASIZE:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int D = 1 << ASIZE;

  logic [DSIZE-1:0] mem [D];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wptr[ASIZE-1:0]] <= push_dat;
  end

  assign head  = mem[rptr[ASIZE-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

endmodule

// File: rtl/fifo_chain.sv
// Cascade of NSTAGE FIFO stages, one word per stage boundary per edge; FIFO_CHAIN_LEVEL_EN adds a level output.
// Latency: a write into an empty chain clears rempty NSTAGE-1 edges after the write edge.
// Backpressure: writes while wfull are dropped (overflow), reads while rempty are ignored (underflow).
module fifo_chain
  import fifo_chain_pkg::*;
#(
  parameter int    DSIZE       = 8,
  parameter int    ASIZE       = 4,
  parameter int    NSTAGE      = 2,
  parameter int    AWFULLSIZE  = 1,
  parameter int    AREMPTYSIZE = 1,
  parameter string FALLTHROUGH = "TRUE"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [DSIZE-1:0]  wdata,
  output logic              wfull,
  output logic              awfull,
  input  logic              rinc,
  output logic [DSIZE-1:0]  rdata,
  output logic              rempty,
  output logic              arempty,
  output logic [NSTAGE-1:0] stage_empty,
  output logic [NSTAGE-1:0] stage_full,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
`ifdef FIFO_CHAIN_LEVEL_EN
 ,output logic [level_width(NSTAGE*(1<<ASIZE))-1:0] level
`endif
);

  localparam int D = 1 << ASIZE;

  logic [NSTAGE-1:0] st_push;
  logic [NSTAGE-1:0] st_pop;
  logic [DSIZE-1:0]  st_in    [NSTAGE];
  logic [DSIZE-1:0]  st_head  [NSTAGE];
  logic [ASIZE:0]    st_count [NSTAGE];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = winc && !stage_full[0];
  assign rd_ok = rinc && !stage_empty[NSTAGE-1];

  assign st_push[0] = wr_ok;
  assign st_in[0]   = wdata;

  // All hand-offs use registered full/empty, so a word advances at most one stage per edge
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k < NSTAGE - 1) begin : g_link
      assign st_pop[k]    = !stage_empty[k] && !stage_full[k+1];
      assign st_push[k+1] = st_pop[k];
      assign st_in[k+1]   = st_head[k];
    end else begin : g_tail
      assign st_pop[k] = rd_ok;
    end

    fifo_chain_stage #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (st_push[k]),
      .push_dat (st_in[k]),
      .pop      (st_pop[k]),
      .head     (st_head[k]),
      .count    (st_count[k]),
      .full     (stage_full[k]),
      .empty    (stage_empty[k])
    );
  end

  assign wfull   = stage_full[0];
  assign rempty  = stage_empty[NSTAGE-1];
  assign awfull  = int'(st_count[0]) >= (D - AWFULLSIZE);
  assign arempty = int'(st_count[NSTAGE-1]) <= AREMPTYSIZE;

  if (FALLTHROUGH == FT_TRUE) begin : g_show_ahead
    assign rdata = stage_empty[NSTAGE-1] ? '0 : st_head[NSTAGE-1];
  end else begin : g_registered
    logic [DSIZE-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rdata_q <= '0;
      else if (rd_ok) rdata_q <= st_head[NSTAGE-1];
    end
    assign rdata = rdata_q;
  end

  // Sticky error flags; a fresh error outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (winc && stage_full[0]) || (overflow && !clr_err);
      underflow <= (rinc && stage_empty[NSTAGE-1]) || (underflow && !clr_err);
    end
  end

`ifdef FIFO_CHAIN_LEVEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               level <= '0;
    else if (wr_ok && !rd_ok) level <= level + 1'b1;
    else if (!wr_ok && rd_ok) level <= level - 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_chain.sv
// Directed plus randomized bench for fifo_chain (DSIZE=8, ASIZE=2, NSTAGE=3) against a queue reference model.
module tb_fifo_chain;

  localparam int DSIZE = 8;
  localparam int ASIZE = 2;
  localparam int NSTAGE = 3;
  localparam int CAP = NSTAGE * (1 << ASIZE);
  localparam int LW = fifo_chain_pkg::level_width(CAP);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             awfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             arempty;
  logic [NSTAGE-1:0] stage_empty;
  logic [NSTAGE-1:0] stage_full;
  logic             overflow;
  logic             underflow;
  logic             clr_err;
`ifdef FIFO_CHAIN_LEVEL_EN
  logic [LW-1:0]    level;
`endif

  int total = 0;
  int passed = 0;
  logic [7:0] model_q[$];

  fifo_chain #(
    .DSIZE       (DSIZE),
    .ASIZE       (ASIZE),
    .NSTAGE      (NSTAGE),
    .AWFULLSIZE  (1),
    .AREMPTYSIZE (1),
    .FALLTHROUGH ("TRUE")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .winc        (winc),
    .wdata       (wdata),
    .wfull       (wfull),
    .awfull      (awfull),
    .rinc        (rinc),
    .rdata       (rdata),
    .rempty      (rempty),
    .arempty     (arempty),
    .stage_empty (stage_empty),
    .stage_full  (stage_full),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
`ifdef FIFO_CHAIN_LEVEL_EN
   ,.level       (level)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef FIFO_CHAIN_LEVEL_EN
    check(tag, 32'(level), exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs; reference queue tracks accepted words
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c,
                      output bit rok, output logic [7:0] rd);
    bit wok;
    logic [31:0] exp;
    winc = w; wdata = d; rinc = r; clr_err = c;
    wok = w && !wfull;
    rok = r && !rempty;
    rd  = rdata;
    tick();
    winc = 0; rinc = 0; clr_err = 0;
    if (rok) begin
      if (model_q.size() != 0) exp = 32'(model_q.pop_front());
      else exp = 32'hDEAD_BEEF;
      check("read_order", 32'(rd), exp);
    end
    if (wok) model_q.push_back(d);
    if (model_q.size() == 0) check("empty_when_model_empty", 32'(rempty), 1);
    if (model_q.size() == CAP) check("full_when_model_full", 32'(wfull), 1);
    check_level("level_vs_model", model_q.size());
  endtask

  initial begin
    bit rok;
    logic [7:0] rd;
    int n;
    int out_idx;
    int in_idx;

    rst_n = 0; winc = 0; wdata = 0; rinc = 0; clr_err = 0;
    #12 rst_n = 1;
    #1;
    // Reset state
    check("rst_rempty", 32'(rempty), 1);
    check("rst_arempty", 32'(arempty), 1);
    check("rst_wfull", 32'(wfull), 0);
    check("rst_awfull", 32'(awfull), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_stage_empty", 32'(stage_empty), 32'b111);
    check("rst_stage_full", 32'(stage_full), 0);
    check("rst_rdata", 32'(rdata), 0);
    check_level("rst_level", 0);
    tick();

    // Latency: write at edge E, visible after E+2
    step(1, 8'hA5, 0, 0, rok, rd);
    check("lat_e0_rempty", 32'(rempty), 1);
    check("lat_e0_stage_empty", 32'(stage_empty), 32'b110);
    step(0, 0, 0, 0, rok, rd);
    check("lat_e1_rempty", 32'(rempty), 1);
    step(0, 0, 0, 0, rok, rd);
    check("lat_e2_rempty", 32'(rempty), 0);
    check("lat_e2_rdata", 32'(rdata), 32'hA5);
    check("lat_e2_arempty", 32'(arempty), 1);
    step(0, 0, 1, 0, rok, rd);
    check("lat_read_taken", 32'(rok), 1);
    check("lat_read_data", 32'(rd), 32'hA5);
    check("lat_after_rempty", 32'(rempty), 1);
    check_level("lat_after_level", 0);

    // Fill: 13 back-to-back writes, last one dropped
    for (int i = 0; i <= 12; i++) step(1, 8'(i), 0, 0, rok, rd);
    check("fill_wfull", 32'(wfull), 1);
    check("fill_awfull", 32'(awfull), 1);
    check("fill_stage_full", 32'(stage_full), 32'b111);
    check("fill_overflow", 32'(overflow), 1);
    check("fill_arempty", 32'(arempty), 0);
    check_level("fill_level", 12);
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 13; cyc++) begin
      if (rempty) begin
        if (n == 12) break;
        step(0, 0, 0, 0, rok, rd);
      end else begin
        step(0, 0, 1, 0, rok, rd);
        check("drain_value", 32'(rd), n);
        n++;
      end
    end
    check("drain_count", n, 12);
    check("drain_overflow_sticky", 32'(overflow), 1);
    step(0, 0, 0, 1, rok, rd);
    check("ovf_cleared", 32'(overflow), 0);

    // Underflow and clear priority
    step(0, 0, 1, 0, rok, rd);
    check("unf_set", 32'(underflow), 1);
    step(0, 0, 0, 1, rok, rd);
    check("unf_cleared", 32'(underflow), 0);
    step(0, 0, 1, 1, rok, rd);
    check("unf_new_error_wins", 32'(underflow), 1);
    step(0, 0, 0, 1, rok, rd);

    // Randomized streaming of 0..31
    in_idx = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 3000 && out_idx < 32; cyc++) begin
      bit w, r;
      w = (in_idx < 32) && ($urandom_range(0, 3) != 0) && !wfull;
      r = ($urandom_range(0, 3) != 0) && !rempty;
      step(w, 8'(in_idx), r, 0, rok, rd);
      if (w) in_idx++;
      if (rok) begin
        check("stream_value", 32'(rd), out_idx);
        out_idx++;
      end
    end
    check("stream_count", out_idx, 32);
    check("stream_overflow", 32'(overflow), 0);
    check("stream_underflow", 32'(underflow), 0);

    // Mid-operation reset discards contents
    for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 0, rok, rd);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, rok, rd);
    check_level("mid_level_before", 6);
    check("mid_rempty_before", 32'(rempty), 0);
    #2 rst_n = 0;
    #1;
    check("mid_rempty_async", 32'(rempty), 1);
    check("mid_stage_empty_async", 32'(stage_empty), 32'b111);
    check_level("mid_level_async", 0);
    rst_n = 1;
    model_q.delete();
    tick();
    step(1, 8'h5A, 0, 0, rok, rd);
    n = 0;
    while (rempty && n < 10) begin
      step(0, 0, 0, 0, rok, rd);
      n++;
    end
    check("mid_refill_latency", n, 2);
    step(0, 0, 1, 0, rok, rd);
    check("mid_refill_data", 32'(rd), 32'h5A);
    check("mid_final_rempty", 32'(rempty), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
